// File: rtl/miner_nonce_dispatcher.sv
// Job-side driver for one miner core: walks a nonce range over the hash_enable/finished
// handshake, compares each digest to the target and reports one result per job.
module miner_nonce_dispatcher #(
  parameter int unsigned NONCE_W  = 32,
  parameter int unsigned DIGEST_W = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [NONCE_W-1:0]  job_nonce_start,
  input  logic [NONCE_W-1:0]  job_nonce_end,
  input  logic [DIGEST_W-1:0] job_target,
  input  logic                abort,
  output logic                hash_enable,
  output logic [NONCE_W-1:0]  nonce,
  input  logic                finished,
  input  logic [DIGEST_W-1:0] digest,
  output logic                result_valid,
  output logic                result_found,
  output logic [NONCE_W-1:0]  result_nonce,
  output logic [31:0]         hashes_done,
  output logic                busy
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q;
  state_e              state_d;
  logic [NONCE_W-1:0]  end_q;
  logic [DIGEST_W-1:0] target_q;
  logic                hit_q;
  logic                last_c;

  assign last_c = (nonce == end_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort takes priority over any core response
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (job_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = abort ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (abort)         state_d = S_DONE;
        else if (finished) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (abort || hit_q || last_c) state_d = S_DONE;
        else                          state_d = S_ISSUE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs decoded from the state register
  always_comb begin
    job_ready    = 1'b0;
    busy         = 1'b1;
    hash_enable  = 1'b0;
    result_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
      end
      S_ISSUE, S_WAIT: hash_enable = 1'b1;
      S_DONE:          result_valid = 1'b1;
      default: ;
    endcase
  end

  // Job datapath: range/target latch, digest compare, result and hash counter
  always_ff @(posedge clk) begin
    if (rst) begin
      nonce        <= '0;
      end_q        <= '0;
      target_q     <= '0;
      hit_q        <= 1'b0;
      result_found <= 1'b0;
      result_nonce <= '0;
      hashes_done  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (job_valid) begin
            nonce        <= job_nonce_start;
            end_q        <= job_nonce_end;
            target_q     <= job_target;
            hit_q        <= 1'b0;
            result_found <= 1'b0;
            result_nonce <= '0;
            hashes_done  <= '0;
          end
        end
        S_ISSUE: begin
          if (abort) begin
            result_found <= 1'b0;
            result_nonce <= nonce;
          end
        end
        S_WAIT: begin
          // A response colliding with abort is counted but never judged
          if (finished) begin
            hit_q <= (digest < target_q);
            if (hashes_done != {CNT_W{1'b1}}) hashes_done <= hashes_done + CNT_W'(1);
          end
          if (abort) begin
            result_found <= 1'b0;
            result_nonce <= nonce;
          end
        end
        S_CHECK: begin
          if (abort) begin
            result_found <= 1'b0;
            result_nonce <= nonce;
          end else if (hit_q) begin
            result_found <= 1'b1;
            result_nonce <= nonce;
          end else if (last_c) begin
            result_found <= 1'b0;
            result_nonce <= end_q;
          end else begin
            nonce <= nonce + NONCE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miner_nonce_dispatcher.sv
// Scoreboard bench for miner_nonce_dispatcher: a core model answers requests, a range-walk
// reference model predicts each job's result, and a monitor checks every result pulse.
module tb_miner_nonce_dispatcher;

  localparam int unsigned NONCE_W  = 32;
  localparam int unsigned DIGEST_W = 256;

  typedef logic [DIGEST_W-1:0] dig_t;
  typedef logic [NONCE_W-1:0]  non_t;
  typedef struct {
    logic        found;
    non_t        nonce;
    logic [31:0] hashes;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  non_t        job_nonce_start;
  non_t        job_nonce_end;
  dig_t        job_target;
  logic        abort;
  logic        hash_enable;
  non_t        nonce;
  logic        finished;
  dig_t        digest;
  logic        result_valid;
  logic        result_found;
  non_t        result_nonce;
  logic [31:0] hashes_done;
  logic        busy;

  logic core_en = 1'b0;
  logic core_fin = 1'b0;
  dig_t core_dig = '0;
  logic man_fin;
  dig_t man_dig;

  assign finished = core_en ? core_fin : man_fin;
  assign digest   = core_en ? core_dig : man_dig;

  miner_nonce_dispatcher #(.NONCE_W(NONCE_W), .DIGEST_W(DIGEST_W)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end), .job_target(job_target),
    .abort(abort), .hash_enable(hash_enable), .nonce(nonce), .finished(finished),
    .digest(digest), .result_valid(result_valid), .result_found(result_found),
    .result_nonce(result_nonce), .hashes_done(hashes_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  res_t exp_res_q[$];
  non_t exp_nonce_q[$];
  dig_t core_dig_q[$];
  dig_t ones = {DIGEST_W{1'b1}};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic dig_t rand256();
    dig_t r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: try start, start+1, ... (mod 2^32) through end; first digest below target wins
  function automatic res_t ref_model(input non_t s, input non_t e, input dig_t t, input dig_t d[$]);
    res_t r;
    non_t diff = e - s;
    longint unsigned span = 64'(diff) + 64'd1;
    r.found  = 1'b0;
    r.nonce  = e;
    r.hashes = 32'(span);
    for (longint unsigned i = 0; i < span; i++) begin
      if (i < 64'(d.size()) && d[i] < t) begin
        r.found  = 1'b1;
        r.nonce  = s + NONCE_W'(i);
        r.hashes = 32'(i + 1);
        break;
      end
    end
    return r;
  endfunction

  task automatic queue_job(input non_t s, input non_t e, input dig_t t, input dig_t d[$]);
    res_t r;
    r = ref_model(s, e, t, d);
    exp_res_q.push_back(r);
    for (int unsigned i = 0; i < r.hashes; i++) begin
      exp_nonce_q.push_back(s + NONCE_W'(i));
      core_dig_q.push_back((i < 32'(d.size())) ? d[i] : ones);
    end
  endtask

  task automatic drive_job(input non_t s, input non_t e, input dig_t t);
    job_nonce_start = s;
    job_nonce_end   = e;
    job_target      = t;
    job_valid       = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_res_q.size() != 0 || !job_ready) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d results still pending, job_ready=%0b", name, exp_res_q.size(), job_ready);
      exp_res_q.delete();
      exp_nonce_q.delete();
      core_dig_q.delete();
    end
  endtask

  // Core model: accepts a request, answers after a random latency with the queued digest
  initial begin : core
    non_t req;
    forever begin
      @(posedge clk); #1;
      core_fin = 1'b0;
      if (core_en && hash_enable) begin
        req = nonce;
        if (exp_nonce_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_request: nonce 0x%0h, none expected", req);
        end else begin
          check("req_nonce", 64'(req), 64'(exp_nonce_q.pop_front()));
        end
        repeat (1 + $urandom_range(0, 3)) @(posedge clk);
        #1;
        check("hold_enable", 64'(hash_enable), 64'(1));
        check("hold_nonce", 64'(nonce), 64'(req));
        core_fin = 1'b1;
        core_dig = (core_dig_q.size() != 0) ? core_dig_q.pop_front() : ones;
        @(posedge clk); #1;
        core_fin = 1'b0;
        core_dig = '0;
        check("gap_low", 64'(hash_enable), 64'(0));
      end
    end
  end

  // Result monitor
  res_t mon_r;
  always @(negedge clk) begin
    if (!rst && result_valid) begin
      if (exp_res_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: found=%0b nonce=0x%0h", result_found, result_nonce);
      end else begin
        mon_r = exp_res_q.pop_front();
        check("result_found", 64'(result_found), 64'(mon_r.found));
        check("result_nonce", 64'(result_nonce), 64'(mon_r.nonce));
        check("hashes_done", 64'(hashes_done), 64'(mon_r.hashes));
        check("result_he_low", 64'(hash_enable), 64'(0));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_job_ready"}, 64'(job_ready), 64'(1));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_hash_enable"}, 64'(hash_enable), 64'(0));
    check({tag, "_nonce"}, 64'(nonce), 64'(0));
    check({tag, "_result_valid"}, 64'(result_valid), 64'(0));
    check({tag, "_result_found"}, 64'(result_found), 64'(0));
    check({tag, "_result_nonce"}, 64'(result_nonce), 64'(0));
    check({tag, "_hashes_done"}, 64'(hashes_done), 64'(0));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    dig_t dq[$];
    dig_t t;
    non_t s;
    non_t e;
    res_t r;
    int   len;
    int   n;

    rst = 1'b1; job_valid = 1'b0; abort = 1'b0; man_fin = 1'b0; man_dig = '0;
    job_nonce_start = '0; job_nonce_end = '0; job_target = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("reset");
    core_en = 1'b1;

    // Immediate hit
    t = dig_t'(1) << 255;
    dq = '{dig_t'(1)};
    queue_job(32'd5, 32'd9, t, dq);
    drive_job(32'd5, 32'd9, t);
    wait_done("hit");

    // Exhaustion
    t = dig_t'(1) << 200;
    dq = '{ones, ones, ones, ones};
    queue_job(32'h10, 32'h13, t, dq);
    drive_job(32'h10, 32'h13, t);
    wait_done("exhaust");

    // Wrap-around with digest equal to target
    t = dig_t'(256);
    dq = '{dig_t'(256), dig_t'(256), dig_t'(255)};
    queue_job(32'hFFFF_FFFF, 32'h1, t, dq);
    drive_job(32'hFFFF_FFFF, 32'h1, t);
    wait_done("wrap");

    // Randomized jobs
    for (int j = 0; j < 40; j++) begin
      s = $urandom;
      if ($urandom_range(0, 3) == 0) s = 32'hFFFF_FFFF - NONCE_W'($urandom_range(0, 3));
      len = $urandom_range(1, 6);
      e = s + NONCE_W'(len - 1);
      t = rand256() >> $urandom_range(0, 64);
      dq.delete();
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 5))
          0:       dq.push_back((t == '0) ? ones : t - dig_t'(1));
          1:       dq.push_back(t);
          2:       dq.push_back(ones);
          default: dq.push_back(rand256());
        endcase
      end
      queue_job(s, e, t, dq);
      drive_job(s, e, t);
      wait_done("random");
    end

    // Back-to-back jobs with job_valid held across completion
    t = dig_t'(1) << 255;
    dq = '{ones, dig_t'(1)};
    queue_job(32'h100, 32'h101, t, dq);
    dq = '{ones};
    queue_job(32'h200, 32'h200, t, dq);
    job_nonce_start = 32'h100; job_nonce_end = 32'h101; job_target = t; job_valid = 1'b1;
    @(posedge clk); #1;
    job_nonce_start = 32'h200; job_nonce_end = 32'h200;
    n = 0;
    while (!result_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_result_seen", 64'(result_valid), 64'(1));
    @(posedge clk); #1;
    check("b2b_ready", 64'(job_ready), 64'(1));
    @(posedge clk); #1;
    job_valid = 1'b0;
    check("b2b_busy", 64'(busy), 64'(1));
    check("b2b_hashes_restart", 64'(hashes_done), 64'(0));
    check("b2b_nonce", 64'(nonce), 64'(32'h200));
    wait_done("b2b");

    core_en = 1'b0;

    // Abort colliding with a winning finished on nonce 7
    r.found = 1'b0; r.nonce = 32'd7; r.hashes = 32'd1;
    exp_res_q.push_back(r);
    drive_job(32'd7, 32'd20, ones);
    @(posedge clk); #1;
    check("abort_wait_he", 64'(hash_enable), 64'(1));
    man_fin = 1'b1; man_dig = '0; abort = 1'b1;
    @(posedge clk); #1;
    man_fin = 1'b0; abort = 1'b0;
    check("abort_he_low", 64'(hash_enable), 64'(0));
    wait_done("abort_collide");

    // Abort while issuing: no digest received
    r.found = 1'b0; r.nonce = 32'h30; r.hashes = 32'd0;
    exp_res_q.push_back(r);
    drive_job(32'h30, 32'h40, ones);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done("abort_issue");

    // Reset while waiting on the second nonce of a job
    drive_job(32'h55, 32'h60, dig_t'(1));
    @(posedge clk); #1;
    man_fin = 1'b1; man_dig = ones;
    @(posedge clk); #1;
    man_fin = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_he", 64'(hash_enable), 64'(1));
    check("pre_reset_nonce", 64'(nonce), 64'(32'h56));
    check("pre_reset_hashes", 64'(hashes_done), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midreset");
    man_fin = 1'b1; man_dig = '0;
    @(posedge clk); #1;
    man_fin = 1'b0;
    @(posedge clk); #1;
    check("stray_job_ready", 64'(job_ready), 64'(1));
    check("stray_busy", 64'(busy), 64'(0));
    check("stray_hashes", 64'(hashes_done), 64'(0));
    check("stray_result_valid", 64'(result_valid), 64'(0));

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
